lcd_receiver: RTL and testbench
===============================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 SHALL have parameter EN_MIN_CYC, default 50: minimum synchronized EN-high cycles for a strobe to be accepted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on RS, EN and DATA.
REQ-003 SHALL have port CLK, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port RS, input, 1: register select (0 = command, 1 = character).
REQ-006 SHALL have port EN, input, 1: enable strobe from the LCD driver.
REQ-007 SHALL have port DATA, input, 8: bus byte.
REQ-008 SHALL have port RD_ADDR, input, 5: display-buffer read index (0-15 line 1, 16-31 line 2).
REQ-009 SHALL have port RD_CHAR, output, 8: buffer byte at RD_ADDR, registered, 1-cycle latency.
REQ-010 SHALL have port CURSOR, output, 5: current write index.
REQ-011 SHALL have port DISP_ON, CURSOR_ON and BLINK_ON, output, 1 each: display-control flags.
REQ-012 SHALL have port BUSY, output, 1: clear sweep in progress.
REQ-013 SHALL have port CMD_STB, output, 1, paired with CMD, output, 8: 1-cycle pulse and byte for each accepted command.
REQ-014 SHALL have port CHAR_STB, output, 1: 1-cycle pulse for each accepted character write.
REQ-015 SHALL have port ERR, output, 1: sticky; set by dropped strobe or unmapped address; cleared only by reset.

Function
REQ-016 SHALL accept a strobe on the synchronized EN falling edge only if EN was high >= EN_MIN_CYC consecutive cycles; the byte is DATA/RS as sampled in the last high cycle; shorter pulses are ignored with no flag.
REQ-017 SHALL use states IDLE and CLEAR; strobes are decoded only in IDLE.
REQ-018 SHALL decode commands by highest set bit: 0x01 clear; 0x02-0x03 home; 0x04-0x07 entry mode (bit1 = increment); 0x08-0x0F display control (bit2 D, bit1 C, bit0 B); 0x10-0x7F accept and pulse CMD_STB with no other effect; 0x80-0xFF set address.
REQ-019 SHALL on clear enter CLEAR, write 0x20 to cells 0..31 one per cycle (32 cycles, BUSY high), set CURSOR=0 and increment mode, then return to IDLE.
REQ-020 SHALL on set address map DDRAM 0x00-0x0F to CURSOR 0-15 and 0x40-0x4F to 16-31; any other address sets ERR and leaves CURSOR unchanged.
REQ-021 SHALL on character write store DATA at CURSOR, then step CURSOR by +1 or -1 modulo 32 (31->0, 0->31).
REQ-022 SHALL on a strobe accepted while BUSY drop it and set ERR.
REQ-023 SHALL assert CMD_STB/CHAR_STB exactly 2 cycles after the synchronized EN falling edge; effects are visible the same cycle.
REQ-024 SHALL keep RD_CHAR reads independent of writes; a same-cycle read and write to one cell returns the old value.

Reset
REQ-025 SHALL on RST low asynchronously force IDLE, CURSOR=0, increment mode, DISP_ON=CURSOR_ON=BLINK_ON=0, BUSY=0, CMD_STB=CHAR_STB=0, CMD=0, ERR=0, RD_CHAR=0, with filter counters and synchronizers cleared.
REQ-026 SHALL leave buffer contents undefined after reset; an interrupted CLEAR is abandoned, not resumed.

Configuration
REQ-027 SHALL when LCD_RECEIVER_STATS_EN is defined add outputs CMD_CNT[15:0] and CHAR_CNT[15:0]: counts of accepted commands and characters, wrapping at 0xFFFF->0, reset to 0.
REQ-028 SHALL when LCD_RECEIVER_STATS_EN is undefined omit both ports and counters, with all other behaviour identical.

Structure
REQ-029 SHALL place command opcodes/masks, the 0x20 blank code, the 0x40 line-2 base, the cell count of 32 and the state encoding in shared package lcd_pkg.
REQ-030 SHALL implement synchronization, glitch filtering and falling-edge detection in sub-module lcd_en_filter, which outputs a 1-cycle strobe with the captured RS and DATA.

Verification
REQ-031 SHALL cover: 0x38, 0x0C, 0x06, 0x01, 0x80 with EN high 100 cycles -> DISP_ON=1, CURSOR_ON=0, BLINK_ON=0, BUSY high for 32 cycles, all cells 0x20, CURSOR=0.
REQ-032 SHALL cover: 0xC0 then chars "M: 3.3" -> cells 16..21 hold 0x4D 0x3A 0x20 0x33 0x2E 0x33, CURSOR=22.
REQ-033 SHALL cover: 0x8F, char 0x41, char 0x42 -> cell 15=0x41, cell 16=0x42; then 0xCF, char 0x43 -> cell 31=0x43, CURSOR=0.
REQ-034 SHALL cover: EN pulse high 10 cycles (EN_MIN_CYC=50) -> no CHAR_STB, buffer unchanged, ERR=0.
REQ-035 SHALL cover: 0x01, then char strobe completing during BUSY -> dropped, ERR=1; address 0x90 -> ERR stays 1, CURSOR unchanged.
REQ-036 SHALL cover: RST low mid-CLEAR -> BUSY=0, IDLE, CURSOR=0 on the next edge; with STATS_EN, counters read 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and command helpers for the character-LCD bus receiver.
// Optional statistics counters are enabled by defining LCD_RECEIVER_STATS_EN.
package lcd_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_CELLS = 32;
  localparam int CELL_AW   = 5;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'h10;

  // Opcode masks, checked from the highest bit downwards.
  localparam logic [7:0] CMD_SETADDR_MASK = 8'h80;
  localparam logic [7:0] CMD_MISC_MASK    = 8'h70;
  localparam logic [7:0] CMD_DISP_MASK    = 8'h08;
  localparam logic [7:0] CMD_ENTRY_MASK   = 8'h04;
  localparam logic [7:0] CMD_HOME_MASK    = 8'h02;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;

  localparam int ENTRY_INC_BIT = 1;
  localparam int DISP_D_BIT    = 2;
  localparam int DISP_C_BIT    = 1;
  localparam int DISP_B_BIT    = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lcd_state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_ADDR
  } lcd_op_e;

  typedef struct packed {
    logic               ok;
    logic [CELL_AW-1:0] idx;
  } ddram_map_t;

  function automatic lcd_op_e decode_cmd(input logic [7:0] cmd);
    if ((cmd & CMD_SETADDR_MASK) != 8'h00)    return OP_ADDR;
    else if ((cmd & CMD_MISC_MASK) != 8'h00)  return OP_NONE;
    else if ((cmd & CMD_DISP_MASK) != 8'h00)  return OP_DISP;
    else if ((cmd & CMD_ENTRY_MASK) != 8'h00) return OP_ENTRY;
    else if ((cmd & CMD_HOME_MASK) != 8'h00)  return OP_HOME;
    else if (cmd == CMD_CLEAR)                return OP_CLEAR;
    else                                      return OP_NONE;
  endfunction

  // Line 1 occupies DDRAM 0x00-0x0F, line 2 starts at 0x40.
  function automatic ddram_map_t map_ddram(input logic [6:0] addr);
    ddram_map_t m;
    m.ok  = 1'b0;
    m.idx = '0;
    if (addr < LINE_LEN) begin
      m.ok  = 1'b1;
      m.idx = {1'b0, addr[3:0]};
    end else if ((addr >= LINE2_BASE) && (addr < (LINE2_BASE + LINE_LEN))) begin
      m.ok  = 1'b1;
      m.idx = {1'b1, addr[3:0]};
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_en_filter.sv
// Synchronizes RS/EN/DATA, rejects EN pulses shorter than EN_MIN_CYC and emits one
// strobe per accepted falling edge carrying the byte seen in the last high cycle.
module lcd_en_filter
  import lcd_pkg::*;
#(
  parameter int EN_MIN_CYC  = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              stb,
  output logic              stb_rs,
  output logic [DATA_W-1:0] stb_data
);

  localparam int CNT_W = $clog2(EN_MIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(EN_MIN_CYC);

  logic [SYNC_STAGES-1:0]             en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0]             rs_sync_q, rs_sync_d;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q, data_sync_d;

  logic              en_prev_q, en_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cap_rs_q, cap_rs_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              stb_q, stb_d;
  logic              stb_rs_q, stb_rs_d;
  logic [DATA_W-1:0] stb_data_q, stb_data_d;

  logic              en_s;
  logic              rs_s;
  logic [DATA_W-1:0] data_s;
  logic              fall;

  always_comb begin
    en_sync_d      = en_sync_q;
    rs_sync_d      = rs_sync_q;
    data_sync_d    = data_sync_q;
    en_sync_d[0]   = en;
    rs_sync_d[0]   = rs;
    data_sync_d[0] = data;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      en_sync_d[i]   = en_sync_q[i-1];
      rs_sync_d[i]   = rs_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign rs_s   = rs_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = en_prev_q & ~en_s;

  // Counter saturates so arbitrarily long pulses still qualify.
  always_comb begin
    en_prev_d  = en_s;
    cnt_d      = '0;
    cap_rs_d   = cap_rs_q;
    cap_data_d = cap_data_q;
    if (en_s) begin
      cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      cap_rs_d   = rs_s;
      cap_data_d = data_s;
    end
    stb_d      = fall && (cnt_q >= CNT_SAT);
    stb_rs_d   = stb_d ? cap_rs_q : stb_rs_q;
    stb_data_d = stb_d ? cap_data_q : stb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q   <= '0;
      rs_sync_q   <= '0;
      data_sync_q <= '0;
      en_prev_q   <= 1'b0;
      cnt_q       <= '0;
      cap_rs_q    <= 1'b0;
      cap_data_q  <= '0;
      stb_q       <= 1'b0;
      stb_rs_q    <= 1'b0;
      stb_data_q  <= '0;
    end else begin
      en_sync_q   <= en_sync_d;
      rs_sync_q   <= rs_sync_d;
      data_sync_q <= data_sync_d;
      en_prev_q   <= en_prev_d;
      cnt_q       <= cnt_d;
      cap_rs_q    <= cap_rs_d;
      cap_data_q  <= cap_data_d;
      stb_q       <= stb_d;
      stb_rs_q    <= stb_rs_d;
      stb_data_q  <= stb_data_d;
    end
  end

  assign stb      = stb_q;
  assign stb_rs   = stb_rs_q;
  assign stb_data = stb_data_q;

endmodule

// File: rtl/lcd_receiver.sv
// Passive HD44780-style bus receiver: decodes commands/characters into a 2x16 display buffer.
// Define LCD_RECEIVER_STATS_EN to add the CMD_CNT/CHAR_CNT statistics outputs.
module lcd_receiver
  import lcd_pkg::*;
#(
  parameter int EN_MIN_CYC  = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RS,
  input  logic       EN,
  input  logic [7:0] DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [4:0] CURSOR,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       BUSY,
  output logic       CMD_STB,
  output logic [7:0] CMD,
  output logic       CHAR_STB,
  output logic       ERR,
  output logic       state_dbg
`ifdef LCD_RECEIVER_STATS_EN
  ,
  output logic [15:0] CMD_CNT,
  output logic [15:0] CHAR_CNT
`endif
);

  // stb is a valid-only pulse (no ready): it is consumed in the single cycle it is high,
  // and anything arriving while the clear sweep runs is dropped and flagged.
  logic              stb;
  logic              stb_rs;
  logic [DATA_W-1:0] stb_data;

  lcd_en_filter #(
    .EN_MIN_CYC (EN_MIN_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_filter (
    .clk     (CLK),
    .rst_n   (RST),
    .rs      (RS),
    .en      (EN),
    .data    (DATA),
    .stb     (stb),
    .stb_rs  (stb_rs),
    .stb_data(stb_data)
  );

  lcd_state_e         state_q, state_d;
  logic [CELL_AW-1:0] clr_idx_q, clr_idx_d;
  logic [CELL_AW-1:0] cursor_q, cursor_d;
  logic               inc_q, inc_d;
  logic               disp_q, disp_d;
  logic               curs_q, curs_d;
  logic               blink_q, blink_d;
  logic               cmd_stb_q, cmd_stb_d;
  logic               char_stb_q, char_stb_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               err_q, err_d;
  logic [7:0]         rd_char_q, rd_char_d;

  logic [7:0]         cells_q [NUM_CELLS];
  logic               we;
  logic [CELL_AW-1:0] waddr;
  logic [7:0]         wdata;
  ddram_map_t         map;

  assign map = map_ddram(stb_data[6:0]);

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    cursor_d   = cursor_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    curs_d     = curs_q;
    blink_d    = blink_q;
    cmd_stb_d  = 1'b0;
    char_stb_d = 1'b0;
    cmd_d      = cmd_q;
    err_d      = err_q;
    we         = 1'b0;
    waddr      = cursor_q;
    wdata      = stb_data;
    unique case (state_q)
      ST_IDLE: begin
        if (stb && stb_rs) begin
          we         = 1'b1;
          char_stb_d = 1'b1;
          cursor_d   = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
        end else if (stb) begin
          cmd_stb_d = 1'b1;
          cmd_d     = stb_data;
          unique case (decode_cmd(stb_data))
            OP_CLEAR: begin
              state_d   = ST_CLEAR;
              clr_idx_d = '0;
              cursor_d  = '0;
              inc_d     = 1'b1;
            end
            OP_HOME:  cursor_d = '0;
            OP_ENTRY: inc_d = stb_data[ENTRY_INC_BIT];
            OP_DISP: begin
              disp_d  = stb_data[DISP_D_BIT];
              curs_d  = stb_data[DISP_C_BIT];
              blink_d = stb_data[DISP_B_BIT];
            end
            OP_ADDR: begin
              if (map.ok) cursor_d = map.idx;
              else        err_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        we        = 1'b1;
        waddr     = clr_idx_q;
        wdata     = BLANK_CHAR;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == CELL_AW'(NUM_CELLS - 1)) state_d = ST_IDLE;
        if (stb) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read is taken from the array before this edge's write lands: old data on collision.
  assign rd_char_d = cells_q[RD_ADDR];

  always_ff @(posedge CLK) begin
    if (we) cells_q[waddr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      clr_idx_q  <= '0;
      cursor_q   <= '0;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      curs_q     <= 1'b0;
      blink_q    <= 1'b0;
      cmd_stb_q  <= 1'b0;
      char_stb_q <= 1'b0;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      rd_char_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      curs_q     <= curs_d;
      blink_q    <= blink_d;
      cmd_stb_q  <= cmd_stb_d;
      char_stb_q <= char_stb_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      rd_char_q  <= rd_char_d;
    end
  end

`ifdef LCD_RECEIVER_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] char_cnt_q, char_cnt_d;

  always_comb begin
    cmd_cnt_d  = cmd_cnt_q + {15'd0, cmd_stb_d};
    char_cnt_d = char_cnt_q + {15'd0, char_stb_d};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_cnt_q  <= '0;
      char_cnt_q <= '0;
    end else begin
      cmd_cnt_q  <= cmd_cnt_d;
      char_cnt_q <= char_cnt_d;
    end
  end

  assign CMD_CNT  = cmd_cnt_q;
  assign CHAR_CNT = char_cnt_q;
`endif

  assign RD_CHAR   = rd_char_q;
  assign CURSOR    = cursor_q;
  assign DISP_ON   = disp_q;
  assign CURSOR_ON = curs_q;
  assign BLINK_ON  = blink_q;
  assign BUSY      = (state_q == ST_CLEAR);
  assign CMD_STB   = cmd_stb_q;
  assign CMD       = cmd_q;
  assign CHAR_STB  = char_stb_q;
  assign ERR       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lcd_receiver.sv
// Self-checking bench for lcd_receiver: directed scenarios plus randomized bus traffic,
// every output compared each cycle against a behavioural model of the display controller.
module tb_lcd_receiver;

  localparam int EN_MIN      = 24;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RS = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic [4:0] RD_ADDR = 5'd0;
  logic [7:0] RD_CHAR;
  logic [4:0] CURSOR;
  logic       DISP_ON, CURSOR_ON, BLINK_ON, BUSY, CMD_STB, CHAR_STB, ERR, state_dbg;
  logic [7:0] CMD;
`ifdef LCD_RECEIVER_STATS_EN
  logic [15:0] CMD_CNT, CHAR_CNT;
`endif

  lcd_receiver #(.EN_MIN_CYC(EN_MIN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RST(RST), .RS(RS), .EN(EN), .DATA(DATA), .RD_ADDR(RD_ADDR),
    .RD_CHAR(RD_CHAR), .CURSOR(CURSOR), .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON),
    .BLINK_ON(BLINK_ON), .BUSY(BUSY), .CMD_STB(CMD_STB), .CMD(CMD), .CHAR_STB(CHAR_STB),
    .ERR(ERR), .state_dbg(state_dbg)
`ifdef LCD_RECEIVER_STATS_EN
    , .CMD_CNT(CMD_CNT), .CHAR_CNT(CHAR_CNT)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [32];
  bit         m_valid [32];
  int         m_cursor, m_busy_left, m_run;
  bit         m_inc, m_d, m_c, m_b, m_err, m_cmd_stb, m_char_stb, m_rd_valid;
  logic [7:0] m_cmd, m_rd;
  logic [8:0] m_last;
  int         m_cmd_cnt, m_char_cnt;
  int         pend_cnt[$];
  logic [8:0] pend_byte[$];
  logic [7:0] exp_q[$];

  bit         was_busy, have_stb;
  logic [8:0] sb;
  int         a;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_cursor = 0; m_busy_left = 0; m_run = 0;
      m_inc = 1; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
      m_cmd_stb = 0; m_char_stb = 0; m_cmd = 8'h00;
      m_rd = 8'h00; m_rd_valid = 1;
      m_cmd_cnt = 0; m_char_cnt = 0;
      pend_cnt.delete(); pend_byte.delete(); exp_q.delete();
    end else begin
      m_cmd_stb = 0; m_char_stb = 0;
      m_rd_valid = m_valid[RD_ADDR];
      m_rd = m_mem[RD_ADDR];
      have_stb = 0;
      for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i]--;
      if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
        have_stb = 1; sb = pend_byte[0];
        void'(pend_cnt.pop_front()); void'(pend_byte.pop_front());
      end
      was_busy = (m_busy_left > 0);
      if (was_busy) begin
        m_mem[32 - m_busy_left] = 8'h20;
        m_valid[32 - m_busy_left] = 1;
        m_busy_left--;
      end
      if (have_stb && was_busy) m_err = 1;
      else if (have_stb && sb[8]) begin
        m_mem[m_cursor] = sb[7:0]; m_valid[m_cursor] = 1;
        m_cursor = (m_cursor + (m_inc ? 1 : 31)) % 32;
        m_char_stb = 1; m_char_cnt = (m_char_cnt + 1) % 65536;
      end else if (have_stb) begin
        m_cmd_stb = 1; m_cmd = sb[7:0]; exp_q.push_back(sb[7:0]);
        m_cmd_cnt = (m_cmd_cnt + 1) % 65536;
        if (sb[7:0] >= 8'h80) begin
          a = int'(sb[6:0]);
          if (a < 16) m_cursor = a;
          else if (a >= 64 && a < 80) m_cursor = a - 64 + 16;
          else m_err = 1;
        end else if (sb[7:0] >= 8'h10) begin
        end else if (sb[7:0] >= 8'h08) begin
          m_d = sb[2]; m_c = sb[1]; m_b = sb[0];
        end else if (sb[7:0] >= 8'h04) m_inc = sb[1];
        else if (sb[7:0] >= 8'h02) m_cursor = 0;
        else if (sb[7:0] == 8'h01) begin
          m_busy_left = 32; m_cursor = 0; m_inc = 1;
        end
      end
      if (EN) begin
        m_run++; m_last = {RS, DATA};
      end else begin
        if (m_run >= EN_MIN) begin
          pend_cnt.push_back(LAT); pend_byte.push_back(m_last);
        end
        m_run = 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int busy_len = 0, last_busy_len = 0, char_pulses = 0;

  always @(posedge CLK) begin
    #1;
    check("cursor", CURSOR, m_cursor[4:0]);
    check("disp_on", DISP_ON, m_d);
    check("cursor_on", CURSOR_ON, m_c);
    check("blink_on", BLINK_ON, m_b);
    check("busy", BUSY, m_busy_left > 0);
    check("state_dbg", state_dbg, m_busy_left > 0);
    check("cmd_stb", CMD_STB, m_cmd_stb);
    check("char_stb", CHAR_STB, m_char_stb);
    check("cmd", CMD, m_cmd);
    check("err", ERR, m_err);
    if (m_rd_valid) check("rd_char", RD_CHAR, m_rd);
`ifdef LCD_RECEIVER_STATS_EN
    check("cmd_cnt", CMD_CNT, m_cmd_cnt[15:0]);
    check("char_cnt", CHAR_CNT, m_char_cnt[15:0]);
`endif
    if (CMD_STB) begin
      if (exp_q.size() == 0) check("cmd_queue_nonempty", 16'd0, 16'd1);
      else check("cmd_queue", CMD, exp_q.pop_front());
    end
    if (CHAR_STB) char_pulses++;
    if (BUSY) busy_len++;
    else if (busy_len > 0) begin
      last_busy_len = busy_len; busy_len = 0;
    end
  end

  // ---------------- drivers ----------------
  bit         rd_hold = 0;
  logic [4:0] rd_fix = 5'd0;

  always @(negedge CLK) RD_ADDR = rd_hold ? rd_fix : 5'($urandom_range(0, 31));

  task automatic send(input bit rs, input logic [7:0] d, input int hi);
    @(negedge CLK);
    RS = rs; DATA = d; EN = 1'b1;
    repeat (hi) @(negedge CLK);
    EN = 1'b0;
    repeat (LAT + 4) @(negedge CLK);
  endtask

  task automatic read_cell(input logic [4:0] addr, input logic [7:0] exp);
    rd_hold = 1; rd_fix = addr;
    @(negedge CLK);
    @(posedge CLK); #1;
    check($sformatf("cell%0d", addr), RD_CHAR, exp);
    rd_hold = 0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  logic [7:0] msg [6];
  logic [7:0] rnd;
  int         cp;

  initial begin
    msg[0] = 8'h4D; msg[1] = 8'h3A; msg[2] = 8'h20;
    msg[3] = 8'h33; msg[4] = 8'h2E; msg[5] = 8'h33;
    repeat (3) @(negedge CLK);
    check("rst_cursor", CURSOR, 5'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_cmd", CMD, 8'h00);
    check("rst_rd_char", RD_CHAR, 8'h00);
    check("rst_disp", {DISP_ON, CURSOR_ON, BLINK_ON}, 3'b000);
    check("rst_stb", {CMD_STB, CHAR_STB}, 2'b00);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // init sequence
    send(0, 8'h38, 100); send(0, 8'h0C, 100); send(0, 8'h06, 100);
    send(0, 8'h01, 100); send(0, 8'h80, 100);
    check("init_disp", {DISP_ON, CURSOR_ON, BLINK_ON}, 3'b100);
    check("init_busy_len", 16'(last_busy_len), 16'd32);
    check("init_cursor", CURSOR, 5'd0);
    for (int i = 0; i < 32; i++) read_cell(5'(i), 8'h20);

    // second line text
    send(0, 8'hC0, 60);
    for (int i = 0; i < 6; i++) send(1, msg[i], 60);
    for (int i = 0; i < 6; i++) read_cell(5'(16 + i), msg[i]);
    check("text_cursor", CURSOR, 5'd22);

    // line crossing and wrap
    send(0, 8'h8F, 60); send(1, 8'h41, 60); send(1, 8'h42, 60);
    read_cell(5'd15, 8'h41); read_cell(5'd16, 8'h42);
    send(0, 8'hCF, 60); send(1, 8'h43, 60);
    read_cell(5'd31, 8'h43);
    check("wrap_up_cursor", CURSOR, 5'd0);
    send(0, 8'h04, 60); send(0, 8'h80, 60); send(1, 8'h78, 60);
    read_cell(5'd0, 8'h78);
    check("wrap_down_cursor", CURSOR, 5'd31);
    send(0, 8'h06, 60);

    // glitch filter boundary
    cp = char_pulses;
    send(1, 8'h5A, 10);
    send(1, 8'h5A, EN_MIN - 1);
    check("short_pulse_ignored", 16'(char_pulses - cp), 16'd0);
    read_cell(5'd31, 8'h43);
    check("short_pulse_err", ERR, 1'b0);
    send(1, 8'h5A, EN_MIN);
    check("min_pulse_taken", 16'(char_pulses - cp), 16'd1);
    read_cell(5'd31, 8'h5A);
    check("min_pulse_cursor", CURSOR, 5'd0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) rnd = 8'($urandom_range(32, 126));
      else begin
        case ($urandom_range(0, 6))
          0: rnd = 8'h80 | 8'($urandom_range(0, 127));
          1: rnd = 8'h80 | 8'($urandom_range(0, 15));
          2: rnd = 8'hC0 | 8'($urandom_range(0, 15));
          3: rnd = 8'h04 | 8'($urandom_range(0, 3));
          4: rnd = 8'h08 | 8'($urandom_range(0, 7));
          5: rnd = 8'($urandom_range(0, 255));
          default: rnd = 8'($urandom_range(1, 3));
        endcase
      end
      send(($urandom_range(0, 1) == 1) && (rnd >= 8'h20), rnd,
           ($urandom_range(0, 3) == 0) ? $urandom_range(3, EN_MIN - 1) : $urandom_range(EN_MIN, EN_MIN + 16));
    end

    // strobe arriving during the clear sweep
    pulse_reset();
    check("pre_drop_err", ERR, 1'b0);
    cp = char_pulses;
    @(negedge CLK); RS = 0; DATA = 8'h01; EN = 1;
    repeat (30) @(negedge CLK); EN = 0;
    @(negedge CLK); RS = 1; DATA = 8'h55; EN = 1;
    repeat (EN_MIN) @(negedge CLK); EN = 0;
    repeat (40) @(negedge CLK);
    check("drop_err", ERR, 1'b1);
    check("drop_no_char", 16'(char_pulses - cp), 16'd0);
    read_cell(5'd0, 8'h20);
    send(0, 8'h90, 40);
    check("bad_addr_err", ERR, 1'b1);
    check("bad_addr_cursor", CURSOR, 5'd0);

    // reset in the middle of a clear sweep
    send(0, 8'h85, 40);
    send(0, 8'h01, 40);
    check("mid_clear_busy", BUSY, 1'b1);
    @(negedge CLK); RST = 0; #1;
    check("abort_busy", BUSY, 1'b0);
    check("abort_state", state_dbg, 1'b0);
    check("abort_cursor", CURSOR, 5'd0);
`ifdef LCD_RECEIVER_STATS_EN
    check("abort_cmd_cnt", CMD_CNT, 16'd0);
    check("abort_char_cnt", CHAR_CNT, 16'd0);
`endif
    repeat (2) @(negedge CLK); RST = 1;
    repeat (40) @(negedge CLK);
    for (int n = 0; n < 8; n++)
      send($urandom_range(0, 1) == 1, 8'($urandom_range(32, 126)), EN_MIN + 4);

    check("cmd_queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
